// File: rtl/reg_arb_pkg.sv
// Shared types and width defaults for the register-bus arbiter.
package reg_arb_pkg;

  localparam int unsigned REG_ARB_ADDR_W = 6;
  localparam int unsigned REG_ARB_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SPI,
    OWN_LOCAL
  } owner_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_ISSUE,
    L_ACK
  } lstate_t;

endpackage

// File: rtl/reg_bus_arb.sv
// Arbitrates the PWM register-file port between the SPI decoder (always wins) and a local req/ack master.
// Optional write lock on LOCK_ADDR is enabled with `define REG_ARB_LOCK_EN.
module reg_bus_arb
  import reg_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = REG_ARB_ADDR_W,
  parameter int unsigned       DATA_W    = REG_ARB_DATA_W,
  parameter logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(6'h3F)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ack,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_err,
  output logic              rf_read,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  lstate_t lstate;
  owner_t  owner;
  logic    lock;
  logic    l_err;
  logic    s_strobe;
  logic    l_grant;
  logic    l_blocked;

  assign s_strobe  = s_read | s_write;
  assign l_grant   = (lstate == L_IDLE) && m_req && !s_strobe;
  assign l_blocked = m_we && lock;

`ifdef REG_ARB_LOCK_EN
  // SPI writes to LOCK_ADDR still reach the register file; bit 0 also shadows into the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= 1'b0;
    end else if (s_write && (s_addr == LOCK_ADDR)) begin
      lock <= s_wdata[0];
    end
  end
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lstate   <= L_IDLE;
      owner    <= OWN_NONE;
      l_err    <= 1'b0;
      s_rdata  <= '0;
      s_rvalid <= 1'b0;
      m_ack    <= 1'b0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
      rf_read  <= 1'b0;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      rf_read  <= 1'b0;
      rf_write <= 1'b0;
      s_rvalid <= 1'b0;
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      owner    <= OWN_NONE;

      if (owner == OWN_SPI && rf_read) begin
        s_rdata  <= rf_rdata;
        s_rvalid <= 1'b1;
      end

      // Both SPI strobes together collapse to a write, so rf_read and rf_write never coincide.
      if (s_strobe) begin
        owner   <= OWN_SPI;
        rf_addr <= s_addr;
        if (s_write) begin
          rf_write <= 1'b1;
          rf_wdata <= s_wdata;
        end else begin
          rf_read <= 1'b1;
        end
      end else if (l_grant) begin
        owner <= OWN_LOCAL;
        l_err <= l_blocked;
        if (!l_blocked) begin
          rf_addr <= m_addr;
          if (m_we) begin
            rf_write <= 1'b1;
            rf_wdata <= m_wdata;
          end else begin
            rf_read <= 1'b1;
          end
        end
      end

      case (lstate)
        L_IDLE: begin
          if (l_grant) lstate <= L_ISSUE;
        end
        L_ISSUE: begin
          lstate <= L_ACK;
          m_ack  <= 1'b1;
          m_err  <= l_err;
          if (rf_read) m_rdata <= rf_rdata;
        end
        L_ACK: begin
          lstate <= L_IDLE;
        end
        default: begin
          lstate <= L_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arb.sv
// Self-checking bench for reg_bus_arb: SPI vector table, directed local/collision/lock/reset sequences, random traffic.
module tb_reg_bus_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_read = 1'b0, s_write = 1'b0;
  logic [5:0] s_addr = '0;
  logic [7:0] s_wdata = '0;
  logic [7:0] s_rdata;
  logic       s_rvalid;
  logic       m_req = 1'b0, m_we = 1'b0;
  logic [5:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic       m_ack;
  logic [7:0] m_rdata;
  logic       m_err;
  logic       rf_read, rf_write;
  logic [5:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;

  logic [7:0] rf_mem [64];
  logic       mem_clr = 1'b1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  reg_bus_arb #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .rf_read(rf_read), .rf_write(rf_write), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file stand-in: combinational read, write on the clock edge.
  assign rf_rdata = rf_mem[rf_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) rf_mem[i] <= 8'h00;
    end else if (rf_write) begin
      rf_mem[rf_addr] <= rf_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, s_rdata, s_rvalid, m_ack, m_rdata, m_err, rf_read, rf_write, rf_addr, rf_wdata};
  endfunction

  typedef struct {
    bit         rd;
    bit         wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    bit         e_rd;
    bit         e_wr;
    bit         e_rv;
    logic [7:0] e_rdata;
  } vec_t;

  typedef struct {
    bit         rd;
    bit         wr;
    bit         spi;
    bit         loc;
    logic [5:0] addr;
    logic [7:0] data;
  } acc_t;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_clr = 1'b1;
    s_read = 1'b0; s_write = 1'b0; m_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
  endtask

  task automatic random_test(input int unsigned ncyc);
    logic [7:0]  mem [64];
    acc_t        cur, nxt;
    logic [5:0]  last_addr;
    logic [7:0]  last_wd, exp_srd, exp_mrd;
    bit          exp_rv, exp_ack, ack_now;
    int unsigned local_ok, r;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    nxt = '{default: '0};
    last_addr = '0; last_wd = '0; exp_srd = '0; exp_mrd = '0;
    exp_rv = 1'b0; exp_ack = 1'b0; local_ok = 0;
    do_reset();
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge clk);
      cur = nxt;
      if (cur.rd || cur.wr) last_addr = cur.addr;
      if (cur.wr) last_wd = cur.data;
      check("rnd_rf_read", rf_read, cur.rd);
      check("rnd_rf_write", rf_write, cur.wr);
      check("rnd_rf_addr", rf_addr, last_addr);
      check("rnd_rf_wdata", rf_wdata, last_wd);
      check("rnd_s_rvalid", s_rvalid, exp_rv);
      check("rnd_s_rdata", s_rdata, exp_srd);
      check("rnd_m_ack", m_ack, exp_ack);
      check("rnd_m_rdata", m_rdata, exp_mrd);
      check("rnd_m_err", m_err, 1'b0);
      ack_now = exp_ack;
      exp_rv  = cur.spi && cur.rd;
      if (exp_rv) exp_srd = mem[cur.addr];
      exp_ack = cur.loc;
      if (cur.loc && cur.rd) exp_mrd = mem[cur.addr];
      if (cur.wr) mem[cur.addr] = cur.data;
      // Well-behaved local master: drop on ack, maybe issue a fresh request.
      if (ack_now) m_req = 1'b0;
      if (!m_req && $urandom_range(0, 2) == 0) begin
        m_req   = 1'b1;
        m_we    = 1'($urandom_range(0, 1));
        m_addr  = 6'($urandom_range(0, 15));
        m_wdata = 8'($urandom);
      end
      r = $urandom_range(0, 9);
      s_read  = (r <= 1) || (r == 4);
      s_write = (r == 2) || (r == 3) || (r == 4);
      s_addr  = 6'($urandom_range(0, 15));
      s_wdata = 8'($urandom);
      nxt = '{default: '0};
      if (s_read || s_write) begin
        nxt.spi = 1'b1; nxt.wr = s_write; nxt.rd = s_read && !s_write;
        nxt.addr = s_addr; nxt.data = s_wdata;
      end else if (m_req && k >= local_ok) begin
        nxt.loc = 1'b1; nxt.wr = m_we; nxt.rd = !m_we;
        nxt.addr = m_addr; nxt.data = m_wdata;
        local_ok = k + 3;
      end
    end
    @(negedge clk);
    s_read = 1'b0; s_write = 1'b0; m_req = 1'b0;
  endtask

  initial begin
    vec_t       vt [9];
    int unsigned nrd, nack, nrv;
    logic [7:0] old4;

    vt[0] = '{rd:0, wr:1, addr:6'h10, wdata:8'h77, e_rd:0, e_wr:1, e_rv:0, e_rdata:8'h00};
    vt[1] = '{rd:0, wr:1, addr:6'h05, wdata:8'hA5, e_rd:0, e_wr:1, e_rv:0, e_rdata:8'h00};
    vt[2] = '{rd:0, wr:1, addr:6'h02, wdata:8'h3C, e_rd:0, e_wr:1, e_rv:0, e_rdata:8'h00};
    vt[3] = '{rd:1, wr:0, addr:6'h02, wdata:8'h00, e_rd:1, e_wr:0, e_rv:1, e_rdata:8'h3C};
    vt[4] = '{rd:1, wr:0, addr:6'h05, wdata:8'h00, e_rd:1, e_wr:0, e_rv:1, e_rdata:8'hA5};
    vt[5] = '{rd:1, wr:1, addr:6'h07, wdata:8'h5A, e_rd:0, e_wr:1, e_rv:0, e_rdata:8'hA5};
    vt[6] = '{rd:1, wr:0, addr:6'h07, wdata:8'h00, e_rd:1, e_wr:0, e_rv:1, e_rdata:8'h5A};
    vt[7] = '{rd:0, wr:1, addr:6'h3F, wdata:8'h00, e_rd:0, e_wr:1, e_rv:0, e_rdata:8'h5A};
    vt[8] = '{rd:1, wr:0, addr:6'h3F, wdata:8'h00, e_rd:1, e_wr:0, e_rv:1, e_rdata:8'h00};

    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1; mem_clr = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      s_read = vt[i].rd; s_write = vt[i].wr; s_addr = vt[i].addr; s_wdata = vt[i].wdata;
      @(negedge clk);
      s_read = 1'b0; s_write = 1'b0;
      check("vec_rf_read", rf_read, vt[i].e_rd);
      check("vec_rf_write", rf_write, vt[i].e_wr);
      check("vec_rf_addr", rf_addr, vt[i].addr);
      if (vt[i].e_wr) check("vec_rf_wdata", rf_wdata, vt[i].wdata);
      check("vec_m_ack", m_ack, 1'b0);
      @(negedge clk);
      check("vec_strobe_1cyc", {rf_read, rf_write}, 2'b00);
      check("vec_s_rvalid", s_rvalid, vt[i].e_rv);
      check("vec_s_rdata", s_rdata, vt[i].e_rdata);
    end

    // Local read with m_req held past the ack: exactly one re-grant.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 6'h10;
    nrd = 0; nack = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rf_read) nrd++;
      if (m_ack) nack++;
      if (i == 1) begin
        check("lrd_rf_read", rf_read, 1'b1);
        check("lrd_rf_addr", rf_addr, 6'h10);
        check("lrd_no_early_ack", m_ack, 1'b0);
      end
      if (i == 2) begin
        check("lrd_m_ack", m_ack, 1'b1);
        check("lrd_m_rdata", m_rdata, 8'h77);
      end
      if (i == 3) check("lrd_ack_pulse", m_ack, 1'b0);
      if (i == 4) check("lrd_regrant", rf_read, 1'b1);
      if (i == 6) m_req = 1'b0;
    end
    check("lrd_access_count", nrd, 2);
    check("lrd_ack_count", nack, 2);

    // Same-cycle collision: SPI first, local next cycle.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b1; m_addr = 6'h01; m_wdata = 8'h11;
    s_write = 1'b1; s_addr = 6'h01; s_wdata = 8'h22;
    @(negedge clk);
    s_write = 1'b0;
    check("col_spi_write", {rf_write, rf_addr, rf_wdata}, {1'b1, 6'h01, 8'h22});
    check("col_no_ack", m_ack, 1'b0);
    @(negedge clk);
    check("col_local_write", {rf_write, rf_addr, rf_wdata}, {1'b1, 6'h01, 8'h11});
    @(negedge clk);
    check("col_m_ack", {m_ack, m_err}, 2'b10);
    m_req = 1'b0;
    @(negedge clk);
    check("col_final_mem", rf_mem[1], 8'h11);

`ifdef REG_ARB_LOCK_EN
    @(negedge clk);
    s_write = 1'b1; s_addr = 6'h3F; s_wdata = 8'h01;
    @(negedge clk);
    s_write = 1'b0;
    old4 = rf_mem[4];
    m_req = 1'b1; m_we = 1'b1; m_addr = 6'h04; m_wdata = 8'h99;
    @(negedge clk);
    check("lock_no_strobe", {rf_read, rf_write}, 2'b00);
    @(negedge clk);
    check("lock_ack_err", {m_ack, m_err}, 2'b11);
    m_req = 1'b0;
    @(negedge clk);
    check("lock_mem_kept", rf_mem[4], old4);
    s_write = 1'b1; s_addr = 6'h3F; s_wdata = 8'h00;
    @(negedge clk);
    s_write = 1'b0;
    m_req = 1'b1; m_we = 1'b1; m_addr = 6'h04; m_wdata = 8'h99;
    @(negedge clk);
    check("unlock_write", {rf_write, rf_addr, rf_wdata}, {1'b1, 6'h04, 8'h99});
    @(negedge clk);
    check("unlock_ack", {m_ack, m_err}, 2'b10);
    m_req = 1'b0;
    @(negedge clk);
    check("unlock_mem", rf_mem[4], 8'h99);
`else
    old4 = 8'h00;
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b1; m_addr = 6'h04; m_wdata = 8'h99;
    @(negedge clk);
    check("nolock_write", {rf_write, rf_addr, rf_wdata}, {1'b1, 6'h04, 8'h99});
    @(negedge clk);
    check("nolock_ack", {m_ack, m_err}, 2'b10);
    m_req = 1'b0;
    @(negedge clk);
    check("nolock_mem", rf_mem[4], 8'h99);
    check("nolock_mem_changed", rf_mem[4] != old4, 1'b1);
`endif

    // Reset while the local access is in L_ISSUE.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 6'h10;
    @(negedge clk);
    check("rstmid_issue", rf_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_outputs", all_outs(), 64'd0);
    m_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nack = 0; nrv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_ack) nack++;
      if (s_rvalid) nrv++;
    end
    check("rstmid_no_ack", nack, 0);
    check("rstmid_no_rvalid", nrv, 0);

    random_test(600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
